// File: rtl/axi4_lite_gpu.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_gpu
//  Purpose  : AXI4-Lite controlled 2D pixel engine. A small register file
//             holds two corner points, a colour and a command. Writing
//             CTRL bit0 starts either a single-pixel plot or an inclusive
//             rectangle fill. The fill issues one framebuffer write per
//             cycle in raster order on a 640x480 surface.
//  Ports    : s_axi_ctrl_aclk / s_axi_ctrl_aresetn - clock, async low reset
//             s_axi_ctrl_ar* / r*  - AXI4-Lite read address / data channels
//             s_axi_ctrl_aw* / w* / b* - AXI4-Lite write channels
//             fbuf_en_wr, fbuf_wrea - framebuffer port / write enables
//             fbuf_addr, fbuf_data  - pixel address (y*640+x) and colour
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_gpu #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int FBUF_ADDR_WIDTH   = 19,
  parameter int FBUF_DATA_WIDTH   = 8
) (
  input  logic                         s_axi_ctrl_aclk,
  input  logic                         s_axi_ctrl_aresetn,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_araddr,
  input  logic                         s_axi_ctrl_arvalid,
  output logic                         s_axi_ctrl_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_rdata,
  output logic [1:0]                   s_axi_ctrl_rresp,
  output logic                         s_axi_ctrl_rvalid,
  input  logic                         s_axi_ctrl_rready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_awaddr,
  input  logic                         s_axi_ctrl_awvalid,
  output logic                         s_axi_ctrl_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_wdata,
  input  logic                         s_axi_ctrl_wvalid,
  output logic                         s_axi_ctrl_wready,
  output logic [1:0]                   s_axi_ctrl_bresp,
  output logic                         s_axi_ctrl_bvalid,
  input  logic                         s_axi_ctrl_bready,
  output logic                         fbuf_en_wr,
  output logic                         fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data
);

  localparam logic [3:0] REG_ID    = 4'h0;
  localparam logic [3:0] REG_CTRL  = 4'h1;
  localparam logic [3:0] REG_P0    = 4'h2;
  localparam logic [3:0] REG_P1    = 4'h3;
  localparam logic [3:0] REG_COLOR = 4'h4;
  localparam logic [3:0] REG_CMD   = 4'h5;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_t;

  logic clk;
  logic rst_n;
  assign clk   = s_axi_ctrl_aclk;
  assign rst_n = s_axi_ctrl_aresetn;

  // Register file
  logic [9:0]                 p0_x, p0_y, p1_x, p1_y;
  logic [FBUF_DATA_WIDTH-1:0] color;
  logic                       cmd;

  // Copies taken at command start so register writes during DRAW are harmless
  logic [9:0]                 lat_x0, lat_y0, lat_x1, lat_y1;
  logic [FBUF_DATA_WIDTH-1:0] lat_color;

  state_t     state, state_next;
  logic [9:0] cur_x, cur_y, cur_x_next, cur_y_next;
  logic       busy;
  logic       wr_hs;
  logic       start;
  logic       empty_rect;
  logic       on_screen;
  logic [19:0] pix_full;
  logic [31:0] rd_word;
  logic        unused_ok;

  assign busy  = (state == ST_DRAW);
  assign wr_hs = s_axi_ctrl_awvalid && s_axi_ctrl_awready &&
                 s_axi_ctrl_wvalid  && s_axi_ctrl_wready;
  assign start = wr_hs && (s_axi_ctrl_awaddr[5:2] == REG_CTRL) &&
                 s_axi_ctrl_wdata[0] && (state == ST_IDLE);

  assign s_axi_ctrl_rresp = 2'b00;
  assign s_axi_ctrl_bresp = 2'b00;

  // Address bits outside [5:2] and unused data bits are intentionally ignored
  assign unused_ok = ^{s_axi_ctrl_araddr, s_axi_ctrl_awaddr, s_axi_ctrl_wdata};

  // --------------------------------------------------------------------------
  // Read channel: ARREADY is a single-cycle pulse, blocked while a response
  // is still pending, so at most one read is in flight.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    case (s_axi_ctrl_araddr[5:2])
      REG_ID:    rd_word = 32'hFFFF_FFFF;
      REG_CTRL:  rd_word = {31'b0, busy};
      REG_P0:    rd_word = {6'b0, p0_y, 6'b0, p0_x};
      REG_P1:    rd_word = {6'b0, p1_y, 6'b0, p1_x};
      REG_COLOR: rd_word = 32'(color);
      REG_CMD:   rd_word = {31'b0, cmd};
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_ctrl_arready <= 1'b0;
      s_axi_ctrl_rvalid  <= 1'b0;
      s_axi_ctrl_rdata   <= '0;
    end else begin
      s_axi_ctrl_arready <= s_axi_ctrl_arvalid && !s_axi_ctrl_arready &&
                            !s_axi_ctrl_rvalid;
      if (s_axi_ctrl_arvalid && s_axi_ctrl_arready) begin
        s_axi_ctrl_rvalid <= 1'b1;
        s_axi_ctrl_rdata  <= AXI_DATA_WIDTH'(rd_word);
      end else if (s_axi_ctrl_rvalid && s_axi_ctrl_rready) begin
        s_axi_ctrl_rvalid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write channel: AW and W are accepted together, only when no write
  // response is outstanding.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_ctrl_awready <= 1'b0;
      s_axi_ctrl_wready  <= 1'b0;
      s_axi_ctrl_bvalid  <= 1'b0;
    end else begin
      s_axi_ctrl_awready <= s_axi_ctrl_awvalid && s_axi_ctrl_wvalid &&
                            !s_axi_ctrl_awready && !s_axi_ctrl_bvalid;
      s_axi_ctrl_wready  <= s_axi_ctrl_awvalid && s_axi_ctrl_wvalid &&
                            !s_axi_ctrl_awready && !s_axi_ctrl_bvalid;
      if (wr_hs) begin
        s_axi_ctrl_bvalid <= 1'b1;
      end else if (s_axi_ctrl_bvalid && s_axi_ctrl_bready) begin
        s_axi_ctrl_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_x  <= '0;
      p0_y  <= '0;
      p1_x  <= '0;
      p1_y  <= '0;
      color <= '0;
      cmd   <= 1'b0;
    end else if (wr_hs) begin
      case (s_axi_ctrl_awaddr[5:2])
        REG_P0: begin
          p0_x <= s_axi_ctrl_wdata[9:0];
          p0_y <= s_axi_ctrl_wdata[25:16];
        end
        REG_P1: begin
          p1_x <= s_axi_ctrl_wdata[9:0];
          p1_y <= s_axi_ctrl_wdata[25:16];
        end
        REG_COLOR: color <= s_axi_ctrl_wdata[FBUF_DATA_WIDTH-1:0];
        REG_CMD:   cmd   <= s_axi_ctrl_wdata[0];
        default: ;
      endcase
    end
  end

  // A plot is treated as a 1x1 rectangle at P0, so the scan logic is shared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_x0    <= '0;
      lat_y0    <= '0;
      lat_x1    <= '0;
      lat_y1    <= '0;
      lat_color <= '0;
    end else if (start) begin
      lat_x0    <= p0_x;
      lat_y0    <= p0_y;
      lat_x1    <= cmd ? p1_x : p0_x;
      lat_y1    <= cmd ? p1_y : p0_y;
      lat_color <= color;
    end
  end

  // --------------------------------------------------------------------------
  // Draw FSM
  // --------------------------------------------------------------------------
  assign empty_rect = (lat_x0 > lat_x1) || (lat_y0 > lat_y1);
  assign on_screen  = (cur_x < SCREEN_W) && (cur_y < SCREEN_H);
  // y*640 = y*512 + y*128
  assign pix_full   = {1'b0, cur_y, 9'b0} + {3'b0, cur_y, 7'b0} + {10'b0, cur_x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      state <= state_next;
      cur_x <= cur_x_next;
      cur_y <= cur_y_next;
    end
  end

  always_comb begin
    state_next = state;
    cur_x_next = cur_x;
    cur_y_next = cur_y;
    fbuf_en_wr = 1'b0;
    fbuf_wrea  = 1'b0;
    fbuf_addr  = '0;
    fbuf_data  = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_DRAW;
          cur_x_next = p0_x;
          cur_y_next = p0_y;
        end
      end
      ST_DRAW: begin
        if (empty_rect) begin
          state_next = ST_IDLE;
        end else begin
          // Off-screen positions still consume a scan cycle, just silently
          if (on_screen) begin
            fbuf_en_wr = 1'b1;
            fbuf_wrea  = 1'b1;
            fbuf_addr  = FBUF_ADDR_WIDTH'(pix_full);
            fbuf_data  = lat_color;
          end
          if (cur_x == lat_x1) begin
            if (cur_y == lat_y1) begin
              state_next = ST_IDLE;
            end else begin
              cur_x_next = lat_x0;
              cur_y_next = cur_y + 10'd1;
            end
          end else begin
            cur_x_next = cur_x + 10'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_gpu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_lite_gpu
//  Purpose  : Directed self-checking bench for axi4_lite_gpu. Drives AXI4-Lite
//             transactions on the falling edge, samples on the falling edge,
//             and records every framebuffer write for later comparison.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_gpu;

  localparam logic [31:0] A_ID    = 32'h00;
  localparam logic [31:0] A_CTRL  = 32'h04;
  localparam logic [31:0] A_P0    = 32'h08;
  localparam logic [31:0] A_P1    = 32'h0C;
  localparam logic [31:0] A_COLOR = 32'h10;
  localparam logic [31:0] A_CMD   = 32'h14;

  logic        clk;
  logic        rst_n;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        fbuf_en_wr;
  logic        fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wrea_err = 0;
  int q_addr[$];
  int q_data[$];
  int q_cyc[$];

  axi4_lite_gpu dut (
    .s_axi_ctrl_aclk    (clk),
    .s_axi_ctrl_aresetn (rst_n),
    .s_axi_ctrl_araddr  (araddr),
    .s_axi_ctrl_arvalid (arvalid),
    .s_axi_ctrl_arready (arready),
    .s_axi_ctrl_rdata   (rdata),
    .s_axi_ctrl_rresp   (rresp),
    .s_axi_ctrl_rvalid  (rvalid),
    .s_axi_ctrl_rready  (rready),
    .s_axi_ctrl_awaddr  (awaddr),
    .s_axi_ctrl_awvalid (awvalid),
    .s_axi_ctrl_awready (awready),
    .s_axi_ctrl_wdata   (wdata),
    .s_axi_ctrl_wvalid  (wvalid),
    .s_axi_ctrl_wready  (wready),
    .s_axi_ctrl_bresp   (bresp),
    .s_axi_ctrl_bvalid  (bvalid),
    .s_axi_ctrl_bready  (bready),
    .fbuf_en_wr         (fbuf_en_wr),
    .fbuf_wrea          (fbuf_wrea),
    .fbuf_addr          (fbuf_addr),
    .fbuf_data          (fbuf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer write recorder
  always @(negedge clk) begin
    if (fbuf_en_wr) begin
      q_addr.push_back(int'(fbuf_addr));
      q_data.push_back(int'(fbuf_data));
      q_cyc.push_back(cyc);
      if (!fbuf_wrea) wrea_err <= wrea_err + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    bit got;
    got     = 1'b0;
    awaddr  = addr;
    wdata   = data;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (awready && wready) got = 1'b1;
    end
    if (!got) check("aw_w_timeout", 64'd0, 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("bvalid_up", bvalid, 1'b1);
    check("bresp", bresp, 2'b00);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp, input int hold, output int lat);
    bit got;
    got     = 1'b0;
    lat     = -1;
    araddr  = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (arready) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (!got) check("ar_timeout", 64'd0, 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_up", rvalid, 1'b1);
    check("rresp", rresp, 2'b00);
    check(tag, rdata, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", rvalid, 1'b1);
      check("rdata_stable", rdata, exp);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_drop", rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int n_mid;
    bit got;

    rst_n   = 1'b0;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;

    // Reset held for 10 cycles with a master trying to talk
    arvalid = 1'b1;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_handshakes", {arready, awready, wready, rvalid, bvalid,
                               fbuf_en_wr, fbuf_wrea}, 7'b0);
    end
    check("rst_data", {rdata, rresp, bresp, fbuf_addr, fbuf_data}, 63'd0);
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ID read via unaligned address, response held 3 cycles
    axi_read("id_read", 32'h01, 32'hFFFF_FFFF, 3, lat);
    check("arready_latency", lat, 0);

    // Reset values and unmapped offset
    axi_read("p0_reset",    A_P0,    32'h0, 0, lat);
    axi_read("p1_reset",    A_P1,    32'h0, 0, lat);
    axi_read("color_reset", A_COLOR, 32'h0, 0, lat);
    axi_read("cmd_reset",   A_CMD,   32'h0, 0, lat);
    axi_read("ctrl_reset",  A_CTRL,  32'h0, 0, lat);
    axi_write(32'h18, 32'hDEAD_BEEF);
    axi_read("unmapped_rd", 32'h18,  32'h0, 0, lat);

    // Single pixel plot at (3,2)
    axi_write(A_COLOR, 32'h0000_005A);
    axi_write(A_P0,    32'h0002_0003);
    axi_write(A_CMD,   32'h0);
    base = q_addr.size();
    axi_write(A_CTRL,  32'h1);
    repeat (6) @(negedge clk);
    check("plot_count", q_addr.size() - base, 1);
    if (q_addr.size() > base) begin
      check("plot_addr", q_addr[base], 1283);
      check("plot_data", q_data[base], 8'h5A);
    end
    axi_read("p0_rdback",    A_P0,    32'h0002_0003, 0, lat);
    axi_write(A_COLOR, 32'hFFFF_FF5A);
    axi_read("color_masked", A_COLOR, 32'h0000_005A, 0, lat);
    axi_write(A_P0, 32'hFFFF_FFFF);
    axi_read("p0_masked",    A_P0,    32'h03FF_03FF, 0, lat);

    // 2x2 fill at the origin
    axi_write(A_P0,  32'h0000_0000);
    axi_write(A_P1,  32'h0001_0001);
    axi_write(A_CMD, 32'h1);
    base = q_addr.size();
    axi_write(A_CTRL, 32'h1);
    axi_read("ctrl_busy_fill", A_CTRL, 32'h1, 0, lat);
    repeat (6) @(negedge clk);
    check("fill_count", q_addr.size() - base, 4);
    if (q_addr.size() >= base + 4) begin
      check("fill_addr0", q_addr[base],     0);
      check("fill_addr1", q_addr[base + 1], 1);
      check("fill_addr2", q_addr[base + 2], 640);
      check("fill_addr3", q_addr[base + 3], 641);
      check("fill_data3", q_data[base + 3], 8'h5A);
      check("fill_consecutive", q_cyc[base + 3] - q_cyc[base], 3);
    end
    axi_read("ctrl_idle_fill", A_CTRL, 32'h0, 0, lat);

    // Inverted rectangle: nothing drawn
    axi_write(A_P0, 32'h0000_0005);
    axi_write(A_P1, 32'h0000_0002);
    base = q_addr.size();
    axi_write(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    check("empty_count", q_addr.size() - base, 0);
    axi_read("ctrl_idle_empty", A_CTRL, 32'h0, 0, lat);

    // 20-pixel line; registers poked and a second start issued mid-draw
    axi_write(A_P0, 32'h000A_0064);
    axi_write(A_P1, 32'h000A_0077);
    base = q_addr.size();
    axi_write(A_CTRL, 32'h1);
    axi_read("ctrl_busy_line", A_CTRL, 32'h1, 0, lat);
    axi_write(A_P0, 32'h0000_0000);
    axi_write(A_COLOR, 32'h0000_0011);
    axi_write(A_CTRL, 32'h1);
    repeat (30) @(negedge clk);
    check("line_count", q_addr.size() - base, 20);
    if (q_addr.size() >= base + 20) begin
      check("line_first", q_addr[base], 6500);
      check("line_last",  q_addr[base + 19], 6519);
      check("line_color", q_data[base + 19], 8'h5A);
    end

    // Scan straddling the screen edge: only (638,479) and (639,479) land
    axi_write(A_P0, 32'h01DF_027E);
    axi_write(A_P1, 32'h01E0_0281);
    base = q_addr.size();
    axi_write(A_CTRL, 32'h1);
    repeat (12) @(negedge clk);
    check("clip_count", q_addr.size() - base, 2);
    if (q_addr.size() >= base + 2) begin
      check("clip_addr0", q_addr[base],     307198);
      check("clip_addr1", q_addr[base + 1], 307199);
      check("clip_data",  q_data[base], 8'h11);
    end

    // Write response back-pressure
    awaddr  = A_COLOR;
    wdata   = 32'h33;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    got     = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (awready) got = 1'b1;
    end
    if (!got) check("bp_aw_timeout", 64'd0, 64'd1);
    @(negedge clk);
    wdata = 32'h44;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid_hold", bvalid, 1'b1);
      check("bp_awready_blocked", {awready, wready}, 2'b00);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bp_bvalid_drop", bvalid, 1'b0);
    check("bp_awready_after_b", awready, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (awready) got = 1'b1;
    end
    check("bp_second_accept", got, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("bp_bvalid2", bvalid, 1'b1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    axi_read("bp_color", A_COLOR, 32'h44, 0, lat);

    // Reset in the middle of a long fill
    axi_write(A_P0, 32'h0000_0000);
    axi_write(A_P1, 32'h0000_027F);
    base = q_addr.size();
    axi_write(A_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    n_mid = q_addr.size() - base;
    check("mid_draw_active", n_mid != 0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_fbuf", {fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data}, 29'd0);
    base = q_addr.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_writes", q_addr.size() - base, 0);
    axi_read("post_rst_ctrl", A_CTRL, 32'h0, 0, lat);
    axi_read("post_rst_p1",   A_P1,   32'h0, 0, lat);

    check("wrea_with_en", wrea_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
